// File: rtl/mem_bus_pkg.sv
// Shared widths and FSM encoding for the memory bus initiator.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StTurn  = 2'd3
  } bus_state_e;

endpackage

// File: rtl/mem_bus_master_if.sv
// Core-side request/response handshake of the memory bus initiator.
interface mem_bus_master_if;
  import mem_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/bus_tristate.sv
// Tri-state driver for the shared memory data bus; the pin value is always readable.
module bus_tristate #(
  parameter int unsigned Width = 8
) (
  input  logic             en_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  inout  wire  [Width-1:0] pin_io
);

  assign pin_io  = en_i ? wdata_i : {Width{1'bz}};
  assign rdata_o = pin_io;

endmodule

// File: rtl/mem_bus_master.sv
// Single-request bus initiator sequencing rd/wr/addr/data of the unified memory.
module mem_bus_master
  import mem_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mem_bus_master_if.master  core,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data
);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] bus_rdata;
  logic              accept;
  logic              rsp_valid_d;
  logic              rsp_valid_q, ready_q, busy_q, rd_q, wr_q, drive_en_q;

  bus_tristate #(
    .Width (DATA_W)
  ) u_tristate (
    .en_i    (drive_en_q),
    .wdata_i (wdata_q),
    .rdata_o (bus_rdata),
    .pin_io  (mem_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    accept  = core.req_valid && ready_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = core.req_we ? StWrite : StRead;
          addr_d  = core.req_addr;
          wdata_d = core.req_wdata;
        end
      end
      StRead: begin
        state_d = StIdle;
        rdata_d = bus_rdata;
      end
      StWrite: state_d = StTurn;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Read response lands in the idle cycle after READ; write response is the TURN cycle.
    rsp_valid_d = (state_q == StRead) || (state_d == StTurn);
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      drive_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      rd_q        <= (state_d == StRead);
      wr_q        <= (state_d == StWrite);
      drive_en_q  <= (state_d == StWrite);
    end
  end

  assign mem_rd         = rd_q;
  assign mem_wr         = wr_q;
  assign mem_addr       = addr_q;
  assign core.req_ready = ready_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rdata_q;
  assign core.busy      = busy_q;

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator for the 32×8 unified program/data memory. It accepts single read or write requests from the CPU core over a valid/ready handshake and sequences the memory's `rd`/`wr`/`addr`/bidirectional `data` pins. It owns the tri-state driver on the data bus and guarantees that `rd` and `wr` are never asserted together. Read data and write acknowledgements return to the core as a one-cycle response pulse. It sits between the controller/datapath and `memory`.

## Interface
- `ADDR_W`, 5: address width (32 words)
- `DATA_W`, 8: data width

- `clk`  in  1  rising-edge clock, shared with memory
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  master can accept a request this cycle
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle pulse: read data valid / write done
- `rsp_rdata`  out  DATA_W  captured read data
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_data`  inout  DATA_W  bidirectional memory data bus
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, READ, WRITE, TURN. All outputs are registered except `mem_data`, which is driven as `drive_en ? wdata_q : 'z`.
- IDLE: `req_ready`=1. A request is accepted on `req_valid && req_ready`, which latches addr/we/wdata. Next state: WRITE if `req_we`, else READ.
- READ: `mem_rd`=1, `mem_wr`=0, `mem_addr`=addr_q, bus released. At the end of the cycle, sample `mem_data` into `rsp_rdata` and go to IDLE with `rsp_valid`=1.
- WRITE: `mem_wr`=1, `mem_rd`=0, `drive_en`=1, `mem_addr`=addr_q. Memory commits at the end of the cycle. Next state: TURN.
- TURN: strobes low, `drive_en`=0, `rsp_valid`=1, `rsp_rdata` unchanged, `req_ready`=0. Next state: IDLE. This mandatory bus-release cycle prevents contention with a following read.
- `req_valid` outside IDLE is ignored. The core holds the request until it is accepted.
- `mem_rd && mem_wr` is never 1. `drive_en` is 1 only in WRITE.
- Undriven (Z/X) bus values during a read are captured as-is. The master does not check them.
- Reset (async, any state): state=IDLE, `req_ready`=1, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `drive_en`=0 (bus released immediately), `rsp_valid`=0, `rsp_rdata`=0, `busy`=0. An in-flight request is dropped with no response. A write interrupted by reset before its commit edge does not occur.

## Timing
- Accept at edge N.
- Read: `mem_rd` high in cycle N+1, `rsp_valid` in N+2. The next request can be accepted in N+2, so sustained reads take 2 cycles each.
- Write: `mem_wr` plus driven data in N+1, memory commit at the end of N+1, `rsp_valid` in N+2 (TURN). The next accept is in N+3, so sustained writes take 3 cycles each.
- `rsp_valid` is exactly one cycle wide, with no backpressure.
- `mem_addr` holds its last value while idle.

## Structure
- Shared package `mem_bus_pkg`: `ADDR_W`/`DATA_W` defaults and state encodings IDLE=2'd0, READ=2'd1, WRITE=2'd2, TURN=2'd3.
- One sub-module, `bus_tristate` (enable, out-data, in-data, inout pin), isolates the Z-drive. All other logic lives in the FSM.

## Test plan
- Reset: assert `rst` mid-cycle. All outputs go to reset values asynchronously, `mem_data` is Z, `req_ready`=1.
- Write 0xA5 to address 0x03, then read 0x03. The write produces `rsp_valid` 2 cycles after accept, and the read returns `rsp_rdata`=0xA5 2 cycles after its accept.
- Back-to-back reads of 0x00 and 0x1F with `req_valid` held. Accepts occur 2 cycles apart and the responses match the preloaded contents.
- Write to 0x10 immediately followed by a read request. The read is accepted only after TURN. No cycle has `mem_rd && mem_wr` or master drive while `mem_rd`=1.
- Assert `rst` during WRITE (before the commit edge). Strobes drop immediately, the bus releases, there is no `rsp_valid`, and the target word is unchanged.
- `req_valid` held constant across a whole read. Exactly one accept and one `rsp_valid` occur, and `busy`=1 only in cycle N+1.
